// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// Register 0 is hardwired to zero and is never busy. Reads are combinational
// with write-first bypass. When several write ports target the same address,
// the highest port index wins. A reserve marks its destination busy; any
// enabled write to an address clears that address's busy bit. If a reserve and
// a write hit the same register in one cycle, the reserve wins.
module regfile_sb #(
    parameter int DEPTH = 32,
    parameter int BITS  = 64,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*BITS-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*BITS-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [AW:0]         busy_cnt
);

    logic [BITS-1:0]  regs   [DEPTH];
    logic [DEPTH-1:0] busy;

    // Per-address write decode: wr_hit[a] is set when some port writes a.
    // wr_val[a] holds the data of the winning (highest-index) port.
    logic [DEPTH-1:0] wr_hit;
    logic [BITS-1:0]  wr_val [DEPTH];
    logic [DEPTH-1:0] rsv_sel;
    logic [DEPTH-1:0] clr_sel;
    logic [AW:0]      clr_cnt;
    logic             set_evt;

    // Decode the write ports per address; later ports overwrite earlier ones.
    // Address 0 is never decoded, so writes to it vanish.
    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            wr_hit[a] = 1'b0;
            wr_val[a] = '0;
        end
        for (int k = 0; k < NWR; k++) begin
            for (int a = 1; a < DEPTH; a++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] == AW'(a))) begin
                    wr_hit[a] = 1'b1;
                    wr_val[a] = wr_data[k*BITS +: BITS];
                end
            end
        end
    end

    // Scoreboard events: one set from the reserve, and any number of clears
    // from writes. A clear is suppressed where the reserve hits the same register.
    always_comb begin
        rsv_sel = '0;
        for (int a = 1; a < DEPTH; a++) begin
            rsv_sel[a] = rsv_en && (rsv_addr == AW'(a));
        end
        set_evt = |(rsv_sel & ~busy);
        clr_sel = busy & wr_hit & ~rsv_sel;
        clr_cnt = '0;
        for (int a = 0; a < DEPTH; a++) begin
            clr_cnt = clr_cnt + {{AW{1'b0}}, clr_sel[a]};
        end
    end

    // Storage, busy bits and busy count; reset discards same-cycle requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                regs[a] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int a = 1; a < DEPTH; a++) begin
                if (wr_hit[a]) begin
                    regs[a] <= wr_val[a];
                end
                busy[a] <= rsv_sel[a] | (busy[a] & ~wr_hit[a]);
            end
            busy[0]  <= 1'b0;
            busy_cnt <= busy_cnt + {{AW{1'b0}}, set_evt} - clr_cnt;
        end
    end

    // Read ports: write-first bypass. A bypassed value is reported ready.
    // Bypass also applies while rst is high, because it only looks at this
    // cycle's inputs and the pre-edge state.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            if (rd_addr[p*AW +: AW] != '0) begin
                if (wr_hit[rd_addr[p*AW +: AW]]) begin
                    rd_data[p*BITS +: BITS] = wr_val[rd_addr[p*AW +: AW]];
                end else begin
                    rd_data[p*BITS +: BITS] = regs[rd_addr[p*AW +: AW]];
                end
                rd_busy[p] = busy[rd_addr[p*AW +: AW]] & ~wr_hit[rd_addr[p*AW +: AW]];
            end
        end
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of architectural registers (power of two, >=2).
REQ-002 SHALL have parameter BITS, default 64, register data width.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (>=1).
REQ-004 SHALL have parameter NWR, default 1, number of write ports (>=1).
REQ-005 SHALL define AW = $clog2(DEPTH); port k of any packed multi-port bus occupies slice [k*W +: W].
REQ-006 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have rd_addr  input  NRD*AW  read addresses.
REQ-009 SHALL have rd_data  output  NRD*BITS  read data.
REQ-010 SHALL have rd_busy  output  NRD  scoreboard busy flag per read address.
REQ-011 SHALL have wr_en  input  NWR  write enables.
REQ-012 SHALL have wr_addr  input  NWR*AW  write addresses.
REQ-013 SHALL have wr_data  input  NWR*BITS  write data.
REQ-014 SHALL have rsv_en  input  1  reserve request (mark destination pending).
REQ-015 SHALL have rsv_addr  input  AW  register to reserve.
REQ-016 SHALL have busy_cnt  output  AW+1  number of registers currently busy.

Function
REQ-017 Register 0 SHALL be hardwired: reads 0, never busy; writes and reserves to it SHALL be ignored.
REQ-018 Writes SHALL commit on the rising edge when wr_en[k]=1; reads SHALL be combinational.
REQ-019 Same-cycle write/read same nonzero address SHALL bypass: rd_data returns wr_data of the winning write port (write-first).
REQ-020 Multiple write ports to the same address in one cycle: highest port index SHALL win, for both storage and bypass.
REQ-021 Scoreboard: one busy bit per register; rsv_en=1 sets busy[rsv_addr] at the edge; any enabled write to address a clears busy[a] at the edge.
REQ-022 Reserve and write to the same address in one cycle: reserve SHALL win (busy=1 after edge; data still written).
REQ-023 Reserve of an already-busy register SHALL leave it busy (no count change, no error).
REQ-024 rd_busy[p] SHALL equal busy[rd_addr[p]] AND NOT (a write to that address this cycle), so a bypassed value is reported ready.
REQ-025 busy_cnt SHALL be a registered count equal to popcount(busy) after each edge; it SHALL update by set/clear events in the same cycle (net +1, -n, or 0), never exceeding DEPTH-1.
REQ-026 Unwritten registers SHALL read 0 after reset.

Reset
REQ-027 With rst=1 at a rising edge, all registers SHALL become 0, all busy bits 0, busy_cnt 0.
REQ-028 rst SHALL override same-cycle wr_en and rsv_en; those requests SHALL be discarded.
REQ-029 During rst=1, combinational bypass SHALL still apply; rd_busy SHALL reflect pre-edge state.

Verification
REQ-030 Reset, then read all addresses on every port -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-031 Write x5=0xDEAD_BEEF, read x5 same cycle on port0 -> rd_data=0xDEAD_BEEF (bypass); next cycle still 0xDEAD_BEEF; write x0=0x1234 -> x0 reads 0.
REQ-032 NWR=2: ports 0 and 1 write x7 with 0x11 and 0x22 same cycle -> x7 reads 0x22 next cycle and in bypass.
REQ-033 rsv x3, next cycle -> rd_busy=1, busy_cnt=1; write x3=0x55 -> same cycle rd_busy=0, rd_data=0x55; after edge busy_cnt=0.
REQ-034 rsv x9 and write x9=0x77 same cycle -> after edge busy=1, data 0x77, busy_cnt=1; rsv x0 -> busy_cnt unchanged.
REQ-035 Reserve x1..x4, assert rst mid-sequence with wr_en=1 to x2 -> after edge all busy 0, busy_cnt=0, x2 reads 0.
